period_scan_ctrl: RTL and testbench

- Scheduler that time-shares one period-measurement counter across N_CH square-wave inputs, scanning them round-robin.
- For each channel it:
  - selects the channel onto the counter input;
  - pulses the counter's start and waits for its done tick;
  - aborts hung measurements by injecting synthetic edges;
  - stores a per-channel period/valid/timeout result behind a registered read port.
- Sits between the board inputs and the counter; the counter shares clk/reset with this block.

---
 rtl/period_scan_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_period_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_scan_ctrl.sv
// Round-robin scheduler that shares one period counter across N_CH inputs,
// aborts hung measurements and keeps per-channel results behind a read port.
module period_scan_ctrl #(
  parameter int N_CH         = 4,
  parameter int CH_W         = 2,
  parameter int CLK_MS_COUNT = 50000,
  parameter int TIMEOUT_MS   = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] sig_in,
  input  logic            pc_ready,
  input  logic            pc_done_tick,
  input  logic [9:0]      pc_prd,
  output logic            pc_start,
  output logic            pc_si,
  input  logic [CH_W-1:0] rd_ch,
  output logic [9:0]      rd_period,
  output logic            rd_valid,
  output logic            rd_timeout,
  output logic            upd_tick,
  output logic [CH_W-1:0] upd_ch,
  output logic            busy
);
  localparam int N_SLOT = 1 << CH_W;
  localparam int PS_W   = $clog2(CLK_MS_COUNT + 1);
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_MS_COUNT - 1);
  localparam logic [10:0]     MS_LIMIT = 11'(TIMEOUT_MS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SEL   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] MEAS  = 3'd3;
  localparam logic [2:0] ABORT = 3'd4;
  localparam logic [2:0] STORE = 3'd5;
  localparam logic [2:0] NEXT  = 3'd6;

  logic [N_CH-1:0]   sync1_reg, sync2_reg;
  logic [N_SLOT-1:0] sync_pad;
  logic [2:0]        state_reg, state_next;
  logic [CH_W-1:0]   cur_ch_reg, cur_ch_next;
  logic              sel_cnt_reg, sel_cnt_next;
  logic [PS_W-1:0]   presc_reg, presc_next;
  logic [10:0]       ms_reg, ms_next;
  logic              abort_tgl_reg, abort_tgl_next;
  logic              good_reg, good_next;
  logic              store_en;
  logic              upd_tick_reg;
  logic [CH_W-1:0]   upd_ch_reg;
  logic [9:0]        period_mem  [N_SLOT];
  logic              valid_mem   [N_SLOT];
  logic              timeout_mem [N_SLOT];
  logic [9:0]        rd_period_reg;
  logic              rd_valid_reg, rd_timeout_reg;

  // Lowest offset (from first_off upward, wrapping) whose mask bit is set.
  function automatic logic [CH_W-1:0] pick(input logic [N_CH-1:0] mask,
                                           input logic [CH_W-1:0] from,
                                           input int first_off);
    int idx;
    pick = from;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = (int'(from) + first_off + k) % N_CH;
      if (mask[idx]) pick = idx[CH_W-1:0];
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sig_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign sync_pad = N_SLOT'(sync2_reg);

  always_comb begin
    state_next     = state_reg;
    cur_ch_next    = cur_ch_reg;
    sel_cnt_next   = 1'b0;
    presc_next     = presc_reg;
    ms_next        = ms_reg;
    abort_tgl_next = 1'b0;
    good_next      = good_reg;
    store_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run && |ch_mask) begin
          cur_ch_next = pick(ch_mask, cur_ch_reg, 0);
          state_next  = SEL;
        end
      end
      SEL: begin
        // Two settle cycles so the counter's edge register sees the new channel.
        sel_cnt_next = 1'b1;
        if (sel_cnt_reg && pc_ready) state_next = START;
      end
      START: begin
        presc_next = '0;
        ms_next    = '0;
        state_next = MEAS;
      end
      MEAS: begin
        if (presc_reg == PS_LAST) begin
          presc_next = '0;
          ms_next    = ms_reg + 11'd1;
        end else begin
          presc_next = presc_reg + PS_W'(1);
        end
        if (pc_done_tick) begin
          good_next  = 1'b1;
          state_next = STORE;
        end else if (ms_reg == MS_LIMIT) begin
          good_next  = 1'b0;
          state_next = ABORT;
        end
      end
      ABORT: begin
        abort_tgl_next = ~abort_tgl_reg;
        if (pc_done_tick) state_next = STORE;
      end
      STORE: begin
        store_en   = 1'b1;
        state_next = NEXT;
      end
      NEXT: begin
        // Advance even when going idle so a resumed scan continues the rotation.
        if (|ch_mask) cur_ch_next = pick(ch_mask, cur_ch_reg, 1);
        state_next = (!run || ch_mask == '0) ? IDLE : SEL;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cur_ch_reg    <= '0;
      sel_cnt_reg   <= 1'b0;
      presc_reg     <= '0;
      ms_reg        <= '0;
      abort_tgl_reg <= 1'b0;
      good_reg      <= 1'b0;
      upd_tick_reg  <= 1'b0;
      upd_ch_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cur_ch_reg    <= cur_ch_next;
      sel_cnt_reg   <= sel_cnt_next;
      presc_reg     <= presc_next;
      ms_reg        <= ms_next;
      abort_tgl_reg <= abort_tgl_next;
      good_reg      <= good_next;
      upd_tick_reg  <= store_en;
      if (store_en) upd_ch_reg <= cur_ch_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
      logic [9:0] period_reg;
      logic       valid_reg, timeout_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          period_reg  <= '0;
          valid_reg   <= 1'b0;
          timeout_reg <= 1'b0;
        end else if (store_en && cur_ch_reg == CH_W'(gi)) begin
          period_reg  <= good_reg ? pc_prd : 10'd0;
          valid_reg   <= good_reg;
          timeout_reg <= ~good_reg;
        end
      end
      assign period_mem[gi]  = period_reg;
      assign valid_mem[gi]   = valid_reg;
      assign timeout_mem[gi] = timeout_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_period_reg  <= '0;
      rd_valid_reg   <= 1'b0;
      rd_timeout_reg <= 1'b0;
    end else begin
      rd_period_reg  <= period_mem[rd_ch];
      rd_valid_reg   <= valid_mem[rd_ch];
      rd_timeout_reg <= timeout_mem[rd_ch];
    end
  end

  assign pc_start   = (state_reg == START);
  assign pc_si      = (state_reg == ABORT) ? abort_tgl_reg : sync_pad[cur_ch_reg];
  assign busy       = (state_reg != IDLE);
  assign upd_tick   = upd_tick_reg;
  assign upd_ch     = upd_ch_reg;
  assign rd_period  = rd_period_reg;
  assign rd_valid   = rd_valid_reg;
  assign rd_timeout = rd_timeout_reg;
endmodule

// File: tb/tb_period_scan_ctrl.sv
// Bench for period_scan_ctrl: square-wave sources, a behavioural period counter
// and a scan-order/result reference model.
module tb_period_scan_ctrl;
  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int CMS  = 10;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] ch_mask = 4'h0;
  logic [3:0] sig_in = 4'h0;
  logic       pc_ready, pc_done_tick;
  logic [9:0] pc_prd;
  logic       pc_start, pc_si;
  logic [1:0] rd_ch = 2'd0;
  logic [9:0] rd_period;
  logic       rd_valid, rd_timeout, upd_tick, busy;
  logic [1:0] upd_ch;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  period_scan_ctrl #(.N_CH(N_CH), .CH_W(CH_W), .CLK_MS_COUNT(CMS), .TIMEOUT_MS(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .ch_mask(ch_mask), .sig_in(sig_in),
    .pc_ready(pc_ready), .pc_done_tick(pc_done_tick), .pc_prd(pc_prd),
    .pc_start(pc_start), .pc_si(pc_si), .rd_ch(rd_ch), .rd_period(rd_period),
    .rd_valid(rd_valid), .rd_timeout(rd_timeout), .upd_tick(upd_tick),
    .upd_ch(upd_ch), .busy(busy)
  );

  // Square-wave sources; a hung channel sits at a fixed level.
  int per [4] = '{40, 40, 40, 40};
  int ph  [4] = '{0, 0, 0, 0};
  bit hung [4];
  bit hung_lvl [4];
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (hung[i]) sig_in[i] = hung_lvl[i];
      else begin
        ph[i] = (ph[i] + 1) % per[i];
        sig_in[i] = (ph[i] < per[i] / 2);
      end
    end
  end

  // Behavioural period counter: after start, time between two rising edges.
  int         m_mode;
  logic       m_prev, m_done;
  logic [9:0] m_prd;
  longint     cyc, m_t1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_prev <= 1'b0; m_done <= 1'b0; m_prd <= '0; cyc <= 0; m_t1 <= 0;
    end else begin
      cyc <= cyc + 1;
      m_prev <= pc_si;
      m_done <= 1'b0;
      if (pc_start) m_mode <= 1;
      else if (m_mode == 1 && pc_si && !m_prev) begin
        m_mode <= 2; m_t1 <= cyc;
      end else if (m_mode == 2 && pc_si && !m_prev) begin
        m_mode <= 0; m_done <= 1'b1; m_prd <= 10'(((cyc - m_t1) / CMS) % 1024);
      end
    end
  end

  bit         frc = 1'b0;
  bit         frc_done = 1'b0;
  logic [9:0] frc_prd = '0;
  assign pc_ready     = frc ? 1'b1 : (m_mode == 0);
  assign pc_done_tick = frc ? frc_done : m_done;
  assign pc_prd       = frc ? frc_prd : m_prd;

  function automatic int next_set(input logic [3:0] m, input int c, input int first_off);
    for (int k = first_off; k < first_off + 4; k++) if (m[(c + k) % 4]) return (c + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; frc = 1'b0; frc_done = 1'b0; rd_ch = 2'd0;
    for (int i = 0; i < 4; i++) hung[i] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pc_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic observe(output bit ok, output int ch, output int p, output bit v, output bit t);
    ok = 1'b0; ch = -1; p = 0; v = 1'b0; t = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (upd_tick) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ch = int'(upd_ch);
      rd_ch = upd_ch;
      @(negedge clk);
      p = int'(rd_period); v = rd_valid; t = rd_timeout;
      $display("update ch=%0d period=%0d valid=%0d timeout=%0d t=%0t", ch, p, v, t, $time);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; ch_mask = 4'hf;
    repeat (3) @(negedge clk);
    total++; if (pc_start !== 1'b0) begin bad++; $display("FAIL reset_pc_start got=%b want=0", pc_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({upd_tick, upd_ch} !== 3'b000) begin bad++; $display("FAIL reset_upd got=%b/%0d want=0/0", upd_tick, upd_ch); end
    total++; if ({rd_period, rd_valid, rd_timeout} !== 12'h0) begin bad++; $display("FAIL reset_rd got=%0d/%b/%b want=0/0/0", rd_period, rd_valid, rd_timeout); end
    run = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_run0_busy got=%b want=0", busy); end
    run = 1'b1; ch_mask = 4'h0;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_mask0_busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    bit ok; int ch, p; bit v, t;
    do_reset();
    per[0] = 50; ch_mask = 4'b0001; run = 1'b1;
    for (int n = 0; n < 3; n++) begin
      observe(ok, ch, p, v, t);
      total++;
      if (!ok || ch != 0 || p != 5 || v !== 1'b1 || t !== 1'b0) begin
        bad++; $display("FAIL single ok=%b ch=%0d p=%0d v=%b t=%b want ch=0 p=5 v=1 t=0", ok, ch, p, v, t);
      end
      if (!ok) break;
    end
  endtask

  task automatic test_multi();
    bit ok; int ch, p; bit v, t; int exp_ch;
    do_reset();
    per[0] = 30; per[1] = 60; per[3] = 90; ch_mask = 4'b1011; run = 1'b1;
    exp_ch = next_set(ch_mask, 0, 0);
    for (int n = 0; n < 6; n++) begin
      observe(ok, ch, p, v, t);
      total++;
      if (!ok || ch != exp_ch) begin bad++; $display("FAIL multi_order ok=%b ch=%0d want=%0d", ok, ch, exp_ch); end
      if (!ok) break;
      total++;
      if (p != per[exp_ch] / CMS || v !== 1'b1 || t !== 1'b0) begin
        bad++; $display("FAIL multi_result ch=%0d p=%0d v=%b t=%b want p=%0d v=1 t=0", ch, p, v, t, per[exp_ch] / CMS);
      end
      exp_ch = next_set(ch_mask, exp_ch, 1);
    end
    rd_ch = 2'd2;
    @(negedge clk);
    total++; if ({rd_period, rd_valid, rd_timeout} !== 12'h0) begin bad++; $display("FAIL multi_ch2 got=%0d/%b/%b want=0/0/0", rd_period, rd_valid, rd_timeout); end
  endtask

  task automatic test_timeout();
    bit ok; int ch, p; bit v, t; bit s201, s202, s203;
    do_reset();
    hung[1] = 1'b1; hung_lvl[1] = 1'b1; ch_mask = 4'b0010;
    repeat (5) @(negedge clk);
    run = 1'b1;
    wait_start(ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_start got=none want=pc_start"); end
    repeat (201) @(negedge clk);
    s201 = pc_si; @(negedge clk); s202 = pc_si; @(negedge clk); s203 = pc_si;
    total++; if ({s201, s202, s203} !== 3'b101) begin bad++; $display("FAIL abort_entry pc_si got=%b%b%b want=101", s201, s202, s203); end
    for (int n = 0; n < 2; n++) begin
      observe(ok, ch, p, v, t);
      total++;
      if (!ok || ch != 1 || p != 0 || v !== 1'b0 || t !== 1'b1) begin
        bad++; $display("FAIL timeout_result ok=%b ch=%0d p=%0d v=%b t=%b want ch=1 p=0 v=0 t=1", ok, ch, p, v, t);
      end
      if (!ok) break;
    end
  endtask

  task automatic test_run_drop();
    bit ok; int ch, p; bit v, t; int starts, busys;
    do_reset();
    per[0] = 40; per[1] = 40; ch_mask = 4'b0011; run = 1'b1;
    wait_start(ok);
    run = 1'b0;
    observe(ok, ch, p, v, t);
    total++;
    if (!ok || ch != 0 || p != 4 || v !== 1'b1) begin bad++; $display("FAIL rundrop_store ok=%b ch=%0d p=%0d v=%b want ch=0 p=4 v=1", ok, ch, p, v); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rundrop_busy got=%b want=0", busy); end
    starts = 0; busys = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      starts += int'(pc_start); busys += int'(busy);
    end
    total++; if (starts != 0 || busys != 0) begin bad++; $display("FAIL rundrop_idle starts=%0d busy_cycles=%0d want 0/0", starts, busys); end
    run = 1'b1;
    observe(ok, ch, p, v, t);
    total++; if (!ok || ch != 1) begin bad++; $display("FAIL rundrop_resume ok=%b ch=%0d want=1", ok, ch); end
  endtask

  task automatic test_reset_mid();
    bit ok; int ch, p; bit v, t;
    do_reset();
    per[0] = 40; per[1] = 60; ch_mask = 4'b0011; run = 1'b1;
    observe(ok, ch, p, v, t);
    wait_start(ok);
    repeat (20) @(negedge clk);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL midreset_pre rd_valid got=%b want=1", rd_valid); end
    #1 reset = 1'b1;
    @(negedge clk);
    total++;
    if ({rd_period, rd_valid, rd_timeout} !== 12'h0 || busy !== 1'b0 || pc_start !== 1'b0 || upd_tick !== 1'b0) begin
      bad++; $display("FAIL midreset_clear rd=%0d/%b/%b busy=%b start=%b upd=%b want all 0", rd_period, rd_valid, rd_timeout, busy, pc_start, upd_tick);
    end
    reset = 1'b0;
    rd_ch = 2'd1;
    @(negedge clk);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midreset_ch1 rd_valid got=%b want=0", rd_valid); end
    observe(ok, ch, p, v, t);
    total++; if (!ok || ch != 0 || p != 4) begin bad++; $display("FAIL midreset_restart ok=%b ch=%0d p=%0d want ch=0 p=4", ok, ch, p); end
  endtask

  task automatic test_done_vs_timeout();
    bit ok; int ch, p; bit v, t; int prd;
    do_reset();
    prd = $urandom_range(1, 1023);
    frc = 1'b1; frc_prd = 10'(prd); ch_mask = 4'b0001; run = 1'b1;
    // Done in the very cycle ms_cnt reaches the limit: good result.
    wait_start(ok);
    repeat (TMO * CMS + 1) @(negedge clk);
    frc_done = 1'b1; @(negedge clk); frc_done = 1'b0;
    observe(ok, ch, p, v, t);
    total++;
    if (!ok || p != prd || v !== 1'b1 || t !== 1'b0) begin bad++; $display("FAIL tie_good ok=%b p=%0d v=%b t=%b want p=%0d v=1 t=0", ok, p, v, t, prd); end
    // One cycle later the abort has begun: timeout result.
    wait_start(ok);
    repeat (TMO * CMS + 2) @(negedge clk);
    frc_done = 1'b1; @(negedge clk); frc_done = 1'b0;
    observe(ok, ch, p, v, t);
    total++;
    if (!ok || p != 0 || v !== 1'b0 || t !== 1'b1) begin bad++; $display("FAIL tie_late ok=%b p=%0d v=%b t=%b want p=0 v=0 t=1", ok, p, v, t); end
    frc = 1'b0;
  endtask

  task automatic test_random();
    bit ok; int ch, p; bit v, t; int exp_ch, ep;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      ch_mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        per[i] = 2 * $urandom_range(10, 40);
        hung[i] = ($urandom_range(0, 3) == 0);
        hung_lvl[i] = 1'($urandom_range(0, 1));
      end
      repeat (5) @(negedge clk);
      run = 1'b1;
      exp_ch = next_set(ch_mask, 0, 0);
      for (int n = 0; n < 8; n++) begin
        observe(ok, ch, p, v, t);
        total++;
        if (!ok || ch != exp_ch) begin bad++; $display("FAIL rand_order mask=%b ok=%b ch=%0d want=%0d", ch_mask, ok, ch, exp_ch); end
        if (!ok) break;
        ep = hung[exp_ch] ? 0 : per[exp_ch] / CMS;
        total++;
        if (p != ep || v !== !hung[exp_ch] || t !== hung[exp_ch]) begin
          bad++; $display("FAIL rand_result ch=%0d p=%0d v=%b t=%b want p=%0d v=%b t=%b", exp_ch, p, v, t, ep, !hung[exp_ch], hung[exp_ch]);
        end
        exp_ch = next_set(ch_mask, exp_ch, 1);
      end
      run = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_timeout();
    test_run_drop();
    test_reset_mid();
    test_done_vs_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog elapsed total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
